// File: rtl/arbitro_sumador.sv
// Shared WIDTH-bit unsigned adder behind an N_REQ-way arbiter with a valid/ack result port.
// Define ARBITRO_PRIORIDAD_FIJA_EN for fixed priority (lowest index wins); default is round-robin.
module arbitro_sumador #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 4,
    parameter int IDW   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic                   valid,
    output logic [WIDTH:0]         rta,
    output logic [IDW-1:0]         rta_id,
    input  logic                   ack
);

    typedef enum logic [1:0] {IDLE, SUMA, ENTREGA} estadoT;

    estadoT                        estado;
    logic [N_REQ-1:0][WIDTH-1:0]   opAArr, opBArr;
    logic [WIDTH-1:0]              opAReg, opBReg;
    logic [IDW-1:0]                ptr, ganador;

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : gDesempaque
            assign opAArr[i] = op_a[i*WIDTH +: WIDTH];
            assign opBArr[i] = op_b[i*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        ganador = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[i]) ganador = IDW'(i);
    end
`else
    int   idx;
    logic hallado;

    // Search starts one past the last winner, wrapping, so every requester gets a turn.
    always_comb begin
        ganador = '0;
        hallado = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!hallado && req[idx]) begin
                hallado = 1'b1;
                ganador = IDW'(idx);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
            gnt    <= '0;
            valid  <= 1'b0;
            rta    <= '0;
            rta_id <= '0;
            opAReg <= '0;
            opBReg <= '0;
            ptr    <= IDW'(N_REQ - 1);
        end else begin
            case (estado)
                IDLE: begin
                    if (|req) begin
                        opAReg <= opAArr[ganador];
                        opBReg <= opBArr[ganador];
                        gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << ganador;
                        ptr    <= ganador;
                        estado <= SUMA;
                    end
                end
                SUMA: begin
                    rta    <= {1'b0, opAReg} + {1'b0, opBReg};
                    rta_id <= ptr;
                    valid  <= 1'b1;
                    gnt    <= '0;
                    estado <= ENTREGA;
                end
                ENTREGA: begin
                    if (ack) begin
                        valid  <= 1'b0;
                        estado <= IDLE;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_sumador.sv
// Scoreboard bench for arbitro_sumador: directed requests push expected grants/results,
// a negedge monitor pops and compares on every grant and every accepted result.
module tb_arbitro_sumador;

    typedef struct packed {
        logic [0:0] id;
        logic [4:0] sum;
    } resT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] opA, opB;
    logic [1:0] gnt;
    logic       valid;
    logic [4:0] rta;
    logic [0:0] rtaId;
    logic       ack;

    resT        expQ[$];
    logic [1:0] gntQ[$];
    resT        monR;
    logic [1:0] monG;
    int         total = 0;
    int         bad   = 0;

    arbitro_sumador #(.N_REQ(2), .WIDTH(4), .IDW(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(opA), .op_b(opB),
        .gnt(gnt), .valid(valid), .rta(rta), .rta_id(rtaId), .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != 2'b00) begin
                if (gntQ.size() == 0) check("gnt_unexpected", gnt, 0);
                else begin
                    monG = gntQ.pop_front();
                    check("gnt", gnt, monG);
                end
            end
            if (valid && ack) begin
                if (expQ.size() == 0) check("result_unexpected", 1, 0);
                else begin
                    monR = expQ.pop_front();
                    check("rta", rta, monR.sum);
                    check("rta_id", rtaId, monR.id);
                end
            end
        end
    end

    task automatic waitGnt(input int id);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = gnt[id];
        end
        check($sformatf("gnt%0d_seen", id), seen, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && (expQ.size() + gntQ.size()) != 0; n++)
            @(negedge clk);
        check("drain", expQ.size() + gntQ.size(), 0);
    endtask

    task automatic push(input logic [1:0] g, input logic id, input logic [4:0] s);
        gntQ.push_back(g);
        expQ.push_back('{id: id, sum: s});
    endtask

    task automatic serve(input int id, input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
        opA[id*4 +: 4] = a;
        opB[id*4 +: 4] = b;
        push(2'b01 << id, 1'(id), s);
        req[id] = 1'b1;
        waitGnt(id);
        req[id] = 1'b0;
        drain();
    endtask

    initial begin
        int         t[4];
        int         cnt;
        logic [0:0] seqId[4];

        rst_n = 1'b0; req = '0; opA = '0; opB = '0; ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_valid", valid, 0);
        check("rst_rta", rta, 0);
        check("rst_rta_id", rtaId, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", valid, 0);

        // Single request, then boundaries
        ack = 1'b1;
        serve(0, 4'h3, 4'h5, 5'h08);
        serve(1, 4'hF, 4'hF, 5'h1E);
        serve(0, 4'h0, 4'h0, 5'h00);

        // Contention: both held; last winner was 0
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
        seqId = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        seqId = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
        opA = 8'h71; opB = 8'h82;
        for (int i = 0; i < 4; i++)
            push(2'b01 << seqId[i], seqId[i], seqId[i] ? 5'd15 : 5'd3);
        req = 2'b11;
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 4; c++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                t[cnt] = c;
                cnt++;
            end
        end
        req = 2'b00;
        check("contention_grants", cnt, 4);
        for (int i = 1; i < 4; i++) check($sformatf("period%0d", i), t[i] - t[i-1], 3);
        drain();

        // Backpressure; operands changed after grant; req0 raised while busy
        ack = 1'b0;
        opA[7:4] = 4'h4; opB[7:4] = 4'h9;
        push(2'b10, 1'b1, 5'd13);
        req[1] = 1'b1;
        waitGnt(1);
        req[1] = 1'b0;
        opA = 8'hF2; opB = 8'hF2;
        push(2'b01, 1'b0, 5'd4);
        req[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", valid, 1);
            check("bp_rta", rta, 13);
            check("bp_rta_id", rtaId, 1);
            check("bp_gnt", gnt, 0);
        end
        @(posedge clk); #1 ack = 1'b1;
        waitGnt(0);
        req[0] = 1'b0;
        drain();

        // Reset while in SUMA: result lost, no pulses afterwards
        opA = 8'h05; opB = 8'h06;
        gntQ.push_back(2'b01);
        req = 2'b01;
        waitGnt(0);
        #1 rst_n = 1'b0; req = 2'b00;
        #1;
        check("midrst_gnt", gnt, 0);
        check("midrst_valid", valid, 0);
        check("midrst_rta", rta, 0);
        check("midrst_rta_id", rtaId, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_valid", valid, 0);
            check("post_rst_gnt", gnt, 0);
        end

        // Pointer reset: requester 0 wins first with both requesting
        opA = 8'h35; opB = 8'h36;
        push(2'b01, 1'b0, 5'd11);
        push(2'b10, 1'b1, 5'd6);
        req = 2'b11;
        waitGnt(0);
        req[0] = 1'b0;
        waitGnt(1);
        req[1] = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
